instruction_fetch_unit: RTL and testbench
=========================================

Name: instruction_fetch_unit

Overview:
Upstream neighbour of the CPU datapath/control unit. Owns the program counter (PC) and fetches 32-bit instructions from instruction memory over a request/response handshake. Holds each fetched word in an instruction register (IR) until the control unit consumes it, then advances the PC according to the control unit's PS code and the K/A-bus operands. Replaces the testbench-driven instruction word with a real fetch path.

Parameters:
ADDR_W, 64, PC and address width.
RESET_PC, 64'h0, PC value loaded on reset.

Ports:
clock  input  1  system clock, rising-edge.
reset  input  1  asynchronous, active-low reset.
imem_req  output  1  fetch request valid.
imem_addr  output  ADDR_W  fetch address; equals pc while imem_req=1.
imem_ready  input  1  memory accepts the request this cycle.
imem_rvalid  input  1  read data valid.
imem_rdata  input  32  instruction word.
ir  output  32  instruction register to the control unit.
ir_valid  output  1  ir holds an unconsumed instruction.
ir_accept  input  1  control unit consumes ir this cycle.
ps  input  3  PC select, sampled on accept.
k  input  ADDR_W  sign-extended word offset from the control word.
a_bus  input  ADDR_W  register operand for indirect jumps.
pc  output  ADDR_W  address of the instruction currently in ir.
pc_plus4  output  ADDR_W  pc+4, for link writes.
align_err  output  1  one-cycle pulse on a misaligned a_bus jump.

Behaviour:
- Reset (reset=0, asynchronous): state=S_IDLE, pc=RESET_PC, ir=32'h0, ir_valid=0, imem_req=0, align_err=0. All outputs stay at these values while reset is held.
- States:
  - S_IDLE -> S_REQ unconditionally on the first clock after reset release.
  - S_REQ: imem_req=1, imem_addr=pc. Stays until imem_ready=1, then -> S_WAIT. imem_rvalid is ignored in S_REQ.
  - S_WAIT: imem_req=0. On imem_rvalid=1: ir<=imem_rdata, ir_valid<=1, -> S_HOLD. Minimum fetch latency is 2 cycles from the request cycle to ir_valid.
  - S_HOLD: ir and pc are stable. On ir_accept=1: ir_valid<=0, pc<=next_pc, -> S_REQ.
- ir_accept is ignored when ir_valid=0.
- ir_valid is a registered output; ir changes only on capture.
- next_pc (modulo 2^ADDR_W wrap, no overflow flag):
  - 3'b000: pc (halt/re-fetch the same address).
  - 3'b001: pc+4.
  - 3'b010: pc + (k<<2).
  - 3'b011: {a_bus[ADDR_W-1:2],2'b00}. If a_bus[1:0]!=0, align_err=1 for exactly the accept cycle+1.
  - Any other code: treated as 3'b001.
- pc_plus4 is combinational pc+4.
- Only one request is ever outstanding. A response arriving in S_IDLE, S_REQ, or S_HOLD is dropped.
- Reset asserted mid-fetch abandons the request. Any stale response after reset release is discarded by the state rule above.
- PC wrap: pc=64'hFFFF_FFFF_FFFF_FFFC with ps=001 gives next pc=0.

Optional Feature:
FETCH_PERF_EN
- Defined: adds output stall_cycles[31:0]. It counts cycles with reset=1 and state in {S_REQ, S_WAIT}. Saturates at 32'hFFFF_FFFF and clears to 0 on reset.
- Undefined: the port and counter are absent; behaviour is otherwise identical.

Test Plan:
- Reset release, memory with imem_ready=1 and data 32'hAB020001 returned the cycle after acceptance -> imem_addr=0 in the first S_REQ cycle; ir=32'hAB020001, ir_valid=1 and pc=0 two cycles after the request.
- Accept with ps=001, then ps=010 and k=64'hFFFF_FFFF_FFFF_FFFF -> next fetches at 0x4, then 0x0.
- ps=011, a_bus=64'h1002 -> fetch at 0x1000; align_err pulses exactly one cycle. A second jump with a_bus=0x2000 gives no pulse.
- imem_ready held low 5 cycles, then rvalid delayed 3 cycles -> imem_req stays high 5 cycles with a stable address. ir_valid rises only on rvalid. With FETCH_PERF_EN, stall_cycles increases by 9 (6 in S_REQ including the accepting cycle, 3 in S_WAIT).
- Reset asserted in S_WAIT, response arrives after release -> response dropped, pc=RESET_PC, ir_valid=0, and a fresh request is issued at RESET_PC.
- ps=000 repeated 3 times -> same address fetched 3 times. Accept pulses with ir_valid=0 are ignored and pc is unchanged.

Source files
------------

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: owns the PC, fetches 32-bit words over a req/ready + rvalid
// handshake into the IR. Optional FETCH_PERF_EN adds a saturating stall_cycles counter.
module instruction_fetch_unit #(
    parameter int unsigned         ADDR_W   = 64,
    parameter logic [ADDR_W-1:0]   RESET_PC = {ADDR_W{1'b0}}
) (
    input  logic                clock,
    input  logic                reset,
    output logic                imem_req,
    output logic [ADDR_W-1:0]   imem_addr,
    input  logic                imem_ready,
    input  logic                imem_rvalid,
    input  logic [31:0]         imem_rdata,
    output logic [31:0]         ir,
    output logic                ir_valid,
    input  logic                ir_accept,
    input  logic [2:0]          ps,
    input  logic [ADDR_W-1:0]   k,
    input  logic [ADDR_W-1:0]   a_bus,
    output logic [ADDR_W-1:0]   pc,
    output logic [ADDR_W-1:0]   pc_plus4,
    output logic                align_err,
`ifdef FETCH_PERF_EN
    output logic [31:0]         stall_cycles,
`endif
    output logic [1:0]          o_dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_HOLD = 2'd3
    } state_t;

    state_t              r_state;
    logic [ADDR_W-1:0]   r_pc;
    logic [31:0]         r_ir;
    logic                r_ir_valid;
    logic                r_imem_req;
    logic                r_align_err;

    logic [ADDR_W-1:0]   w_pc_plus4;
    logic [ADDR_W-1:0]   w_next_pc;
    logic                w_misaligned;
    logic                w_accept;

    always_comb begin
        w_pc_plus4   = r_pc + ADDR_W'(4);
        w_misaligned = (ps == 3'b011) && (a_bus[1:0] != 2'b00);
        w_accept     = ir_accept && r_ir_valid;
        case (ps)
            3'b000:  w_next_pc = r_pc;
            3'b010:  w_next_pc = r_pc + (k << 2);
            3'b011:  w_next_pc = {a_bus[ADDR_W-1:2], 2'b00};
            default: w_next_pc = w_pc_plus4;
        endcase
    end

    // Handshake: a request transfers on a cycle with imem_req && imem_ready; exactly one
    // response (imem_rvalid) is then taken in S_WAIT, and any rvalid seen elsewhere is dropped.
    // The IR is offered with ir_valid and consumed on a cycle with ir_valid && ir_accept.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_pc        <= RESET_PC;
            r_ir        <= 32'h0;
            r_ir_valid  <= 1'b0;
            r_imem_req  <= 1'b0;
            r_align_err <= 1'b0;
        end else begin
            r_align_err <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_state    <= S_REQ;
                    r_imem_req <= 1'b1;
                end
                S_REQ: begin
                    if (imem_ready) begin
                        r_state    <= S_WAIT;
                        r_imem_req <= 1'b0;
                    end
                end
                S_WAIT: begin
                    if (imem_rvalid) begin
                        r_ir       <= imem_rdata;
                        r_ir_valid <= 1'b1;
                        r_state    <= S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (w_accept) begin
                        r_ir_valid  <= 1'b0;
                        r_pc        <= w_next_pc;
                        r_imem_req  <= 1'b1;
                        r_align_err <= w_misaligned;
                        r_state     <= S_REQ;
                    end
                end
                default: begin
                    r_state    <= S_IDLE;
                    r_imem_req <= 1'b0;
                end
            endcase
        end
    end

`ifdef FETCH_PERF_EN
    logic [31:0] r_stall_cycles;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_stall_cycles <= 32'h0;
        end else if (((r_state == S_REQ) || (r_state == S_WAIT)) &&
                     (r_stall_cycles != 32'hFFFF_FFFF)) begin
            r_stall_cycles <= r_stall_cycles + 32'd1;
        end
    end

    assign stall_cycles = r_stall_cycles;
`endif

    assign imem_req    = r_imem_req;
    assign imem_addr   = r_pc;
    assign ir          = r_ir;
    assign ir_valid    = r_ir_valid;
    assign pc          = r_pc;
    assign pc_plus4    = w_pc_plus4;
    assign align_err   = r_align_err;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed self-checking bench for instruction_fetch_unit; builds with or without FETCH_PERF_EN.
module tb_instruction_fetch_unit;

    localparam int ADDR_W = 64;

    logic                clock;
    logic                reset;
    logic                imem_req;
    logic [ADDR_W-1:0]   imem_addr;
    logic                imem_ready;
    logic                imem_rvalid;
    logic [31:0]         imem_rdata;
    logic [31:0]         ir;
    logic                ir_valid;
    logic                ir_accept;
    logic [2:0]          ps;
    logic [ADDR_W-1:0]   k;
    logic [ADDR_W-1:0]   a_bus;
    logic [ADDR_W-1:0]   pc;
    logic [ADDR_W-1:0]   pc_plus4;
    logic                align_err;
    logic [1:0]          o_dbg_state;
`ifdef FETCH_PERF_EN
    logic [31:0]         stall_cycles;
`endif

    int total = 0;
    int bad   = 0;

    instruction_fetch_unit #(.ADDR_W(ADDR_W), .RESET_PC(64'h0)) dut (
        .clock       (clock),
        .reset       (reset),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ready  (imem_ready),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .ir          (ir),
        .ir_valid    (ir_valid),
        .ir_accept   (ir_accept),
        .ps          (ps),
        .k           (k),
        .a_bus       (a_bus),
        .pc          (pc),
        .pc_plus4    (pc_plus4),
        .align_err   (align_err),
`ifdef FETCH_PERF_EN
        .stall_cycles(stall_cycles),
`endif
        .o_dbg_state (o_dbg_state)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Wait for a request, hold off ready for rdy_dly cycles, then answer rv_dly+1 cycles later.
    task automatic do_fetch(input logic [63:0] exp_addr, input int rdy_dly, input int rv_dly,
                            input logic [31:0] data);
        int n;
        n = 0;
        while (imem_req !== 1'b1 && n < 20) begin
            @(posedge clock); #1;
            n++;
        end
        total++;
        if (imem_req !== 1'b1) begin
            bad++;
            $display("FAIL fetch_req_timeout: imem_req=%b required 1", imem_req);
        end
        total++;
        if (imem_addr !== exp_addr) begin
            bad++;
            $display("FAIL fetch_addr: got %h required %h", imem_addr, exp_addr);
        end
        for (int i = 0; i < rdy_dly; i++) begin
            imem_ready = 1'b0;
            @(posedge clock); #1;
            total++;
            if (imem_req !== 1'b1 || imem_addr !== exp_addr) begin
                bad++;
                $display("FAIL req_hold: req=%b addr=%h required 1 %h", imem_req, imem_addr, exp_addr);
            end
        end
        imem_ready = 1'b1;
        @(posedge clock); #1;
        imem_ready = 1'b0;
        total++;
        if (imem_req !== 1'b0) begin
            bad++;
            $display("FAIL req_drop: imem_req=%b required 0", imem_req);
        end
        for (int i = 0; i < rv_dly; i++) begin
            @(posedge clock); #1;
            total++;
            if (ir_valid !== 1'b0) begin
                bad++;
                $display("FAIL early_valid: ir_valid=%b required 0", ir_valid);
            end
        end
        imem_rvalid = 1'b1;
        imem_rdata  = data;
        @(posedge clock); #1;
        imem_rvalid = 1'b0;
        total++;
        if (ir_valid !== 1'b1 || ir !== data || pc !== exp_addr) begin
            bad++;
            $display("FAIL capture: valid=%b ir=%h pc=%h required 1 %h %h",
                     ir_valid, ir, pc, data, exp_addr);
        end
    endtask

    task automatic do_accept(input logic [2:0] p, input logic [63:0] kk, input logic [63:0] ab,
                             input logic [63:0] exp_pc, input logic exp_err);
        ir_accept = 1'b1;
        ps        = p;
        k         = kk;
        a_bus     = ab;
        @(posedge clock); #1;
        ir_accept = 1'b0;
        ps        = 3'b000;
        k         = '0;
        a_bus     = '0;
        total++;
        if (ir_valid !== 1'b0 || pc !== exp_pc || imem_req !== 1'b1) begin
            bad++;
            $display("FAIL accept_ps%b: valid=%b pc=%h req=%b required 0 %h 1",
                     p, ir_valid, pc, imem_req, exp_pc);
        end
        total++;
        if (align_err !== exp_err) begin
            bad++;
            $display("FAIL align_pulse: got %b required %b", align_err, exp_err);
        end
        @(posedge clock); #1;
        total++;
        if (align_err !== 1'b0 || pc !== exp_pc) begin
            bad++;
            $display("FAIL align_clear: align_err=%b pc=%h required 0 %h", align_err, pc, exp_pc);
        end
    endtask

    task automatic test_reset;
        reset       = 1'b0;
        imem_ready  = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;
        ir_accept   = 1'b0;
        ps          = 3'b000;
        k           = '0;
        a_bus       = '0;
        repeat (3) @(posedge clock);
        #1;
        total++;
        if (imem_req !== 1'b0 || ir_valid !== 1'b0 || ir !== 32'h0 || pc !== 64'h0 ||
            align_err !== 1'b0 || o_dbg_state !== 2'd0) begin
            bad++;
            $display("FAIL reset_state: req=%b valid=%b ir=%h pc=%h err=%b st=%0d required all zero",
                     imem_req, ir_valid, ir, pc, align_err, o_dbg_state);
        end
`ifdef FETCH_PERF_EN
        total++;
        if (stall_cycles !== 32'h0) begin
            bad++;
            $display("FAIL reset_stall: got %0d required 0", stall_cycles);
        end
`endif
        reset = 1'b1;
        #1;
        total++;
        if (imem_req !== 1'b0) begin
            bad++;
            $display("FAIL idle_req: imem_req=%b required 0", imem_req);
        end
        @(posedge clock); #1;
        total++;
        if (imem_req !== 1'b1 || o_dbg_state !== 2'd1) begin
            bad++;
            $display("FAIL first_req: req=%b st=%0d required 1 1", imem_req, o_dbg_state);
        end
    endtask

    task automatic test_first_fetch;
        do_fetch(64'h0, 0, 0, 32'hAB02_0001);
        total++;
        if (pc_plus4 !== 64'h4) begin
            bad++;
            $display("FAIL pc_plus4: got %h required 4", pc_plus4);
        end
    endtask

    task automatic test_branches;
        do_accept(3'b001, 64'h0, 64'h0, 64'h4, 1'b0);
        do_fetch(64'h4, 0, 0, 32'h0000_0004);
        do_accept(3'b010, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 64'h0, 1'b0);
        do_fetch(64'h0, 0, 0, 32'h0000_0008);
    endtask

    task automatic test_jump;
        do_accept(3'b011, 64'h0, 64'h1002, 64'h1000, 1'b1);
        do_fetch(64'h1000, 0, 0, 32'h0000_1000);
        do_accept(3'b011, 64'h0, 64'h2000, 64'h2000, 1'b0);
        do_fetch(64'h2000, 0, 0, 32'h0000_2000);
    endtask

    task automatic test_stall;
        logic [31:0] sc0;
        do_accept(3'b001, 64'h0, 64'h0, 64'h2004, 1'b0);
`ifdef FETCH_PERF_EN
        sc0 = stall_cycles;
`else
        sc0 = 32'h0;
`endif
        do_fetch(64'h2004, 5, 2, 32'h5A5A_0001);
`ifdef FETCH_PERF_EN
        total++;
        if (stall_cycles - sc0 !== 32'd9) begin
            bad++;
            $display("FAIL stall_count: delta=%0d required 9", stall_cycles - sc0);
        end
`else
        if (sc0 != 32'h0) $display("note: unexpected counter snapshot");
`endif
    endtask

    task automatic test_reset_mid_fetch;
        do_accept(3'b001, 64'h0, 64'h0, 64'h2008, 1'b0);
        imem_ready = 1'b1;
        @(posedge clock); #1;
        imem_ready = 1'b0;
        total++;
        if (o_dbg_state !== 2'd2) begin
            bad++;
            $display("FAIL mid_wait_state: got %0d required 2", o_dbg_state);
        end
        reset = 1'b0;
        #1;
        total++;
        if (pc !== 64'h0 || ir_valid !== 1'b0 || imem_req !== 1'b0 || ir !== 32'h0) begin
            bad++;
            $display("FAIL async_reset: pc=%h valid=%b req=%b ir=%h required 0 0 0 0",
                     pc, ir_valid, imem_req, ir);
        end
        @(posedge clock); #1;
`ifdef FETCH_PERF_EN
        total++;
        if (stall_cycles !== 32'h0) begin
            bad++;
            $display("FAIL stall_clear: got %0d required 0", stall_cycles);
        end
`endif
        reset       = 1'b1;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hDEAD_BEEF;
        @(posedge clock); #1;
        total++;
        if (ir_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 64'h0) begin
            bad++;
            $display("FAIL stale_idle: valid=%b req=%b addr=%h required 0 1 0",
                     ir_valid, imem_req, imem_addr);
        end
        @(posedge clock); #1;
        imem_rvalid = 1'b0;
        total++;
        if (ir_valid !== 1'b0 || o_dbg_state !== 2'd1) begin
            bad++;
            $display("FAIL stale_req: valid=%b st=%0d required 0 1", ir_valid, o_dbg_state);
        end
        do_fetch(64'h0, 0, 0, 32'h1111_2222);
    endtask

    task automatic test_halt;
        for (int i = 0; i < 3; i++) begin
            do_accept(3'b000, 64'h0, 64'h0, 64'h0, 1'b0);
            ir_accept = 1'b1;
            ps        = 3'b001;
            @(posedge clock); #1;
            ir_accept = 1'b0;
            ps        = 3'b000;
            total++;
            if (pc !== 64'h0 || o_dbg_state !== 2'd1) begin
                bad++;
                $display("FAIL ignored_accept: pc=%h st=%0d required 0 1", pc, o_dbg_state);
            end
            do_fetch(64'h0, 0, 0, 32'h3300_0000 + i);
        end
    endtask

    task automatic test_wrap;
        do_accept(3'b011, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFC, 1'b1);
        do_fetch(64'hFFFF_FFFF_FFFF_FFFC, 0, 0, 32'h7777_0000);
        total++;
        if (pc_plus4 !== 64'h0) begin
            bad++;
            $display("FAIL pc_plus4_wrap: got %h required 0", pc_plus4);
        end
        do_accept(3'b001, 64'h0, 64'h0, 64'h0, 1'b0);
        do_fetch(64'h0, 0, 0, 32'h7777_0001);
        do_accept(3'b111, 64'h0, 64'h0, 64'h4, 1'b0);
        do_fetch(64'h4, 1, 0, 32'h7777_0002);
    endtask

    initial begin
        test_reset;
        test_first_fetch;
        test_branches;
        test_jump;
        test_stall;
        test_reset_mid_fetch;
        test_halt;
        test_wrap;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
